// File: rtl/bin2bcd_16b.sv
// bin2bcd_16b: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts one bit per clock. A conversion starts on a rising edge of start seen in idle.
// The result appears on bcd with a one-cycle done pulse, WIDTH+1 cycles after the
// accepted edge.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - conversion request, rising-edge detected (level-tolerant)
//   bin    - unsigned binary input, sampled on the accepted start edge
//   bcd    - packed BCD result, bcd[3:0] = units; held until the next completion
//   busy   - high while shifting
//   done   - one-cycle pulse when bcd is updated
module bin2bcd_16b #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ShW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [ShW-1:0]    sh_q, sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              done_q, done_d;

  logic [BcdW-1:0]   bcd_field;
  logic [BcdW-1:0]   bcd_adj;
  logic [ShW-1:0]    sh_next;

  // Add-3 correction on every nibble in parallel, then shift the whole register left.
  // Nibbles never carry into each other: a digit <= 9 becomes at most 12.
  always_comb begin
    bcd_field = sh_q[ShW-1 -: BcdW];
    bcd_adj   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_field[4*i +: 4] >= 4'd5) ? bcd_field[4*i +: 4] + 4'd3
                                                          : bcd_field[4*i +: 4];
    end
    sh_next = {bcd_adj[BcdW-2:0], sh_q[WIDTH-1:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !start_q) begin
          sh_d    = {{BcdW{1'b0}}, bin};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // done is registered so it rises together with the updated bcd.
        bcd_d   = sh_q[ShW-1 -: BcdW];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q == StShift);
  assign done = done_q;

endmodule
